// File: rtl/cpu16_core_param.sv
// cpu16_core_param
//   Parametrised multicycle accumulator CPU. Instructions are fetched over a
//   req/ack instruction port. Data loads and stores go over a separate req/ack
//   data port. The core also has a hardware return-address stack and a
//   latched output port.
//
// Ports
//   clock        in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-high
//   imem_req     out  1       instruction fetch request, held until imem_ack
//   imem_addr    out  ADDR_W  fetch address (= pc)
//   imem_ack     in   1       fetch data valid this cycle
//   imem_rdata   in   DATA_W  instruction word
//   dmem_req     out  1       data access request, held until dmem_ack
//   dmem_we      out  1       1 = write, 0 = read
//   dmem_addr    out  ADDR_W  data address (instruction address field)
//   dmem_wdata   out  DATA_W  store data (selected register)
//   dmem_ack     in   1       access complete / read data valid this cycle
//   dmem_rdata   in   DATA_W  read data
//   io_in        in   DATA_W  input port, sampled by IN
//   io_out       out  DATA_W  output latch, written by OUT
//   io_out_valid out  1       one-cycle pulse when io_out updates
//   pc           out  ADDR_W  program counter
//   halted       out  1       core executed HALT
//   fault        out  1       return-stack overflow/underflow trap
module cpu16_core_param #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int NREG        = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    localparam int RSEL_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W   = SIDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd1;
    localparam logic [5:0] OP_LOAD  = 6'd2;
    localparam logic [5:0] OP_JUMP  = 6'd3;
    localparam logic [5:0] OP_JNEG  = 6'd4;
    localparam logic [5:0] OP_SUB   = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_OR    = 6'd7;
    localparam logic [5:0] OP_AND   = 6'd8;
    localparam logic [5:0] OP_JPOS  = 6'd9;
    localparam logic [5:0] OP_JZERO = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SHL   = 6'd12;
    localparam logic [5:0] OP_SHR   = 6'd13;
    localparam logic [5:0] OP_IN    = 6'd14;
    localparam logic [5:0] OP_OUT   = 6'd15;
    localparam logic [5:0] OP_CALL  = 6'd16;
    localparam logic [5:0] OP_RET   = 6'd17;
    localparam logic [5:0] OP_HALT  = 6'd63;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_DREAD, S_DWRITE, S_HALT, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [SP_W-1:0]     sp_q, sp_d, sp_m1;
    logic [DATA_W-1:0]   io_out_q, io_out_d;
    logic                io_out_valid_q, io_out_valid_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

    logic                reg_we;
    logic [DATA_W-1:0]   reg_wdata;
    logic                push_en;

    logic [5:0]          op;
    logic [RSEL_W-1:0]   rs;
    logic [ADDR_W-1:0]   a;
    logic [DATA_W-1:0]   rval;

    assign op    = ir_q[DATA_W-1 -: 6];
    assign rs    = ir_q[ADDR_W+RSEL_W-1:ADDR_W];
    assign a     = ir_q[ADDR_W-1:0];
    assign rval  = regs_q[rs];
    assign sp_m1 = sp_q - 1'b1;

    // Memory-operand ALU; anything that is not a two-operand op is LOAD.
    function automatic logic [DATA_W-1:0] alu(input logic [5:0]        f,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_XOR:  return x ^ y;
            OP_OR:   return x | y;
            OP_AND:  return x & y;
            default: return y;
        endcase
    endfunction

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_LOAD: state_d = S_DREAD;
                    OP_STORE: state_d = S_DWRITE;
                    OP_CALL:  state_d = (sp_q == SP_FULL) ? S_FAULT : S_FETCH;
                    OP_RET:   state_d = (sp_q == '0) ? S_FAULT : S_FETCH;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_DREAD:  if (dmem_ack) state_d = S_FETCH;
            S_DWRITE: if (dmem_ack) state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    // Datapath next-state: single register write port, stack push/pop
    always_comb begin
        pc_d           = pc_q;
        ir_d           = ir_q;
        sp_d           = sp_q;
        push_en        = 1'b0;
        reg_we         = 1'b0;
        reg_wdata      = rval;
        io_out_d       = io_out_q;
        io_out_valid_d = 1'b0;
        halted_d       = halted_q;
        fault_d        = fault_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_JUMP:  pc_d = a;
                    OP_JNEG:  if (rval[DATA_W-1]) pc_d = a;
                    OP_JZERO: if (rval == '0) pc_d = a;
                    OP_JPOS:  if (!rval[DATA_W-1] && (rval != '0)) pc_d = a;
                    OP_ADDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = rval + DATA_W'(a);
                    end
                    OP_SHL: begin
                        reg_we    = 1'b1;
                        reg_wdata = rval << a[3:0];
                    end
                    OP_SHR: begin
                        reg_we    = 1'b1;
                        reg_wdata = rval >> a[3:0];
                    end
                    OP_IN: begin
                        reg_we    = 1'b1;
                        reg_wdata = io_in;
                    end
                    OP_OUT: begin
                        io_out_d       = rval;
                        io_out_valid_d = 1'b1;
                    end
                    OP_CALL: begin
                        // pc already points past the CALL, so it is the return address
                        if (sp_q == SP_FULL) begin
                            fault_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + 1'b1;
                            pc_d    = a;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            fault_d = 1'b1;
                        end else begin
                            sp_d = sp_m1;
                            pc_d = stack_q[sp_m1[SIDX_W-1:0]];
                        end
                    end
                    OP_HALT:  halted_d = 1'b1;
                    default:  ;
                endcase
            end
            S_DREAD: begin
                if (dmem_ack) begin
                    reg_we    = 1'b1;
                    reg_wdata = alu(op, rval, dmem_rdata);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q           <= '0;
            ir_q           <= '0;
            sp_q           <= '0;
            io_out_q       <= '0;
            io_out_valid_q <= 1'b0;
            halted_q       <= 1'b0;
            fault_q        <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            sp_q           <= sp_d;
            io_out_q       <= io_out_d;
            io_out_valid_q <= io_out_valid_d;
            halted_q       <= halted_d;
            fault_q        <= fault_d;
            if (reg_we) regs_q[rs] <= reg_wdata;
        end
    end

    // Stack contents are only meaningful below sp, so they need no reset.
    always_ff @(posedge clock) begin
        if (push_en) stack_q[sp_q[SIDX_W-1:0]] <= pc_q;
    end

    // Outputs; requests are gated by reset so they drop the moment reset rises.
    always_comb begin
        imem_req   = (state_q == S_FETCH) && !reset;
        imem_addr  = pc_q;
        dmem_req   = ((state_q == S_DREAD) || (state_q == S_DWRITE)) && !reset;
        dmem_we    = (state_q == S_DWRITE) && !reset;
        dmem_addr  = a;
        dmem_wdata = rval;
    end

    assign io_out       = io_out_q;
    assign io_out_valid = io_out_valid_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_cpu16_core_param.sv
module tb_cpu16_core_param;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req, dmem_req, dmem_we;
    logic [AW-1:0] imem_addr, dmem_addr, pc;
    logic          imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0, dmem_rdata = '0, dmem_wdata;
    logic [DW-1:0] io_in = '0, io_out;
    logic          io_out_valid, halted, fault;

    cpu16_core_param #(.DATA_W(DW), .ADDR_W(AW), .NREG(4), .STACK_DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .io_in(io_in), .io_out(io_out), .io_out_valid(io_out_valid),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;

    localparam logic [5:0] ADD = 0, STORE = 1, LOAD = 2, JUMP = 3, JNEG = 4, SUB = 5, XORO = 6,
                           ORO = 7, ANDO = 8, JPOS = 9, JZERO = 10, ADDI = 11, SHL = 12,
                           SHR = 13, INO = 14, OUTO = 15, CALL = 16, RET = 17, NOP = 20, HALT = 63;

    logic [DW-1:0] imem [256];
    logic [DW-1:0] dmem [256];

    int n_cmp = 0, n_fail = 0;
    int idly = 0, drdly = 0, dwdly = 0;
    int icnt = 0, dcnt = 0;
    int wr_cycles = 0, io_pulses = 0, overlap = 0;
    bit wr_stable = 1'b1;
    logic [AW-1:0] wr_addr0;
    logic [DW-1:0] wr_data0;

    logic [31:0] exp_wr[$], obs_wr[$];
    logic [DW-1:0] exp_io[$], obs_io[$];
    logic [AW-1:0] exp_fetch[$], obs_fetch[$];

    function automatic logic [DW-1:0] enc(input logic [5:0] op, input logic [1:0] rs,
                                          input logic [7:0] a);
        return {op, rs, a};
    endfunction

    // Memory responders and output monitors, all on the falling edge.
    always @(negedge clock) begin
        int d;
        if (imem_req && dmem_req) overlap++;
        if (imem_req) begin
            imem_rdata = imem[imem_addr];
            imem_ack   = (icnt >= idly);
            if (imem_ack) obs_fetch.push_back(imem_addr);
            icnt++;
        end else begin
            imem_ack = 1'b0;
            icnt     = 0;
        end
        if (dmem_req) begin
            d          = dmem_we ? dwdly : drdly;
            dmem_rdata = dmem[dmem_addr];
            dmem_ack   = (dcnt >= d);
            if (dmem_we) begin
                if (wr_cycles == 0) begin
                    wr_addr0 = dmem_addr;
                    wr_data0 = dmem_wdata;
                end else if (dmem_addr !== wr_addr0 || dmem_wdata !== wr_data0) begin
                    wr_stable = 1'b0;
                end
                wr_cycles++;
                if (dmem_ack) begin
                    dmem[dmem_addr] = dmem_wdata;
                    obs_wr.push_back({8'h00, dmem_addr, dmem_wdata});
                end
            end
            dcnt++;
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
        if (io_out_valid) begin
            obs_io.push_back(io_out);
            io_pulses++;
        end
    end

    task automatic start_reset();
        #2 reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = enc(NOP, 2'd0, 8'd0);
            dmem[i] = '0;
        end
        idly = 0; drdly = 0; dwdly = 0;
        wr_cycles = 0; io_pulses = 0; overlap = 0; wr_stable = 1'b1;
        exp_wr.delete(); obs_wr.delete(); exp_io.delete(); obs_io.delete();
        exp_fetch.delete(); obs_fetch.delete();
    endtask

    task automatic release_reset();
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int c = 0;
        while (!(halted || fault) && c < maxc) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (!(halted || fault)) begin
            n_fail++;
            $display("FAIL %s_timeout: halted=%b fault=%b, required completion within %0d cycles",
                     nm, halted, fault, maxc);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        start_reset();
        @(negedge clock);
        n_cmp++;
        if ({imem_req, dmem_req, dmem_we, halted, fault, io_out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/req/we/halt/fault/valid=%b required 000000",
                     {imem_req, dmem_req, dmem_we, halted, fault, io_out_valid});
        end
        n_cmp++;
        if (pc !== 8'h00 || io_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h io_out=%h required 00/0000", pc, io_out);
        end
        release_reset();
        @(negedge clock);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00 || dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: imem_req=%b addr=%h dmem_req=%b required 1/00/0",
                     imem_req, imem_addr, dmem_req);
        end
    endtask

    task automatic test_load_add_jneg();
        start_reset();
        dmem[8'h10] = 16'h7FFF;
        dmem[8'h11] = 16'h0001;
        imem[0]     = enc(LOAD, 0, 8'h10);
        imem[1]     = enc(ADD,  0, 8'h11);
        imem[2]     = enc(JNEG, 0, 8'h20);
        imem[3]     = enc(HALT, 0, 8'h00);
        imem[8'h20] = enc(STORE, 0, 8'h50);
        imem[8'h21] = enc(HALT, 0, 8'h00);
        exp_wr.push_back(32'h0050_8000);
        release_reset();
        wait_done(200, "load_add");
        n_cmp++;
        if (halted !== 1'b1 || fault !== 1'b0 || pc !== 8'h22) begin
            n_fail++;
            $display("FAIL jneg_taken: halted=%b fault=%b pc=%h required 1/0/22", halted, fault, pc);
        end
        n_cmp++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL load_add_wcount: %0d writes, required %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [31:0] e, o;
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL load_add_result: write %h required %h", o, e);
            end
        end
        begin
            int reqs = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (imem_req || dmem_req) reqs++;
            end
            n_cmp++;
            if (reqs != 0 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_absorbing: %0d request cycles, halted=%b required 0/1", reqs, halted);
            end
        end
    endtask

    task automatic test_store_stall();
        start_reset();
        dwdly = 5;
        dmem[8'h60] = 16'hBEEF;
        imem[0] = enc(LOAD,  1, 8'h60);
        imem[1] = enc(STORE, 1, 8'h30);
        imem[2] = enc(HALT,  0, 8'h00);
        exp_wr.push_back(32'h0030_BEEF);
        release_reset();
        wait_done(200, "store");
        n_cmp++;
        if (wr_cycles != 6 || wr_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL store_hold: req cycles=%0d stable=%b required 6/1", wr_cycles, wr_stable);
        end
        n_cmp++;
        if (obs_wr.size() != 1) begin
            n_fail++;
            $display("FAIL store_count: %0d writes, required 1", obs_wr.size());
        end
        if (obs_wr.size() > 0) begin
            logic [31:0] e, o;
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL store_data: write %h required %h", o, e);
            end
        end
        n_cmp++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL req_overlap: %0d cycles with both requests, required 0", overlap);
        end
    endtask

    task automatic test_call_ret();
        start_reset();
        imem[5]     = enc(CALL, 0, 8'h40);
        imem[8'h40] = enc(RET,  0, 8'h00);
        imem[6]     = enc(RET,  0, 8'h00);
        for (int i = 0; i < 6; i++) exp_fetch.push_back(AW'(i));
        exp_fetch.push_back(8'h40);
        exp_fetch.push_back(8'h06);
        release_reset();
        wait_done(200, "call_ret");
        n_cmp++;
        if (obs_fetch.size() != exp_fetch.size()) begin
            n_fail++;
            $display("FAIL call_fetch_count: %0d fetches, required %0d", obs_fetch.size(), exp_fetch.size());
        end
        while (exp_fetch.size() > 0 && obs_fetch.size() > 0) begin
            logic [AW-1:0] e, o;
            e = exp_fetch.pop_front();
            o = obs_fetch.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL call_fetch_addr: fetched %h required %h", o, e);
            end
        end
        // The second RET underflows only if the first one returned sp to 0.
        n_cmp++;
        if (fault !== 1'b1 || halted !== 1'b0 || pc !== 8'h07) begin
            n_fail++;
            $display("FAIL ret_sp_zero: fault=%b halted=%b pc=%h required 1/0/07", fault, halted, pc);
        end
    endtask

    task automatic test_stack_fault();
        int reqs;
        start_reset();
        for (int i = 0; i < 9; i++) imem[i] = enc(CALL, 0, AW'(i + 1));
        release_reset();
        wait_done(200, "overflow");
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (imem_req || dmem_req) reqs++;
        end
        n_cmp++;
        if (fault !== 1'b1 || pc !== 8'h09 || reqs != 0) begin
            n_fail++;
            $display("FAIL stack_overflow: fault=%b pc=%h req cycles=%0d required 1/09/0", fault, pc, reqs);
        end
        start_reset();
        imem[0] = enc(RET, 0, 8'h00);
        release_reset();
        wait_done(100, "underflow");
        n_cmp++;
        if (fault !== 1'b1 || halted !== 1'b0 || pc !== 8'h01) begin
            n_fail++;
            $display("FAIL stack_underflow: fault=%b halted=%b pc=%h required 1/0/01", fault, halted, pc);
        end
    endtask

    task automatic test_io();
        start_reset();
        io_in   = 16'h1234;
        imem[0] = enc(INO,  2, 8'h00);
        imem[1] = enc(SHL,  2, 8'h04);
        imem[2] = enc(OUTO, 2, 8'h00);
        imem[3] = enc(HALT, 0, 8'h00);
        exp_io.push_back(16'h2340);
        release_reset();
        wait_done(100, "io");
        n_cmp++;
        if (io_pulses != 1 || io_out !== 16'h2340 || io_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL io_pulse: pulses=%0d io_out=%h valid=%b required 1/2340/0",
                     io_pulses, io_out, io_out_valid);
        end
        if (obs_io.size() > 0) begin
            logic [DW-1:0] e, o;
            e = exp_io.pop_front();
            o = obs_io.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL io_value: out %h required %h", o, e);
            end
        end
    endtask

    task automatic test_alu_branches();
        start_reset();
        drdly = 1;
        dmem[8'h70] = 16'h00F0;
        dmem[8'h71] = 16'h0F0F;
        dmem[8'h72] = 16'h0005;
        imem[0]  = enc(LOAD,  3, 8'h70);
        imem[1]  = enc(ORO,   3, 8'h71);
        imem[2]  = enc(OUTO,  3, 8'h00);
        imem[3]  = enc(ANDO,  3, 8'h71);
        imem[4]  = enc(OUTO,  3, 8'h00);
        imem[5]  = enc(XORO,  3, 8'h70);
        imem[6]  = enc(SUB,   3, 8'h72);
        imem[7]  = enc(ADDI,  3, 8'h06);
        imem[8]  = enc(OUTO,  3, 8'h00);
        imem[9]  = enc(SHR,   3, 8'h1C);
        imem[10] = enc(NOP,   0, 8'h00);
        imem[11] = enc(JZERO, 3, 8'h30);
        imem[12] = enc(JPOS,  3, 8'h20);
        imem[13] = enc(HALT,  0, 8'h00);
        imem[8'h20] = enc(OUTO,  3, 8'h00);
        imem[8'h21] = enc(LOAD,  0, 8'h72);
        imem[8'h22] = enc(SUB,   0, 8'h71);
        imem[8'h23] = enc(OUTO,  0, 8'h00);
        imem[8'h24] = enc(JPOS,  0, 8'h30);
        imem[8'h25] = enc(JNEG,  0, 8'h28);
        imem[8'h26] = enc(HALT,  0, 8'h00);
        imem[8'h28] = enc(ADDI,  1, 8'h00);
        imem[8'h29] = enc(JZERO, 1, 8'h2C);
        imem[8'h2A] = enc(HALT,  0, 8'h00);
        imem[8'h2C] = enc(OUTO,  1, 8'h00);
        imem[8'h2D] = enc(HALT,  0, 8'h00);
        imem[8'h30] = enc(HALT,  0, 8'h00);
        exp_io.push_back(16'h0FFF);
        exp_io.push_back(16'h0F0F);
        exp_io.push_back(16'h1000);
        exp_io.push_back(16'h0001);
        exp_io.push_back(16'hF0F6);
        exp_io.push_back(16'h0000);
        release_reset();
        wait_done(400, "alu");
        n_cmp++;
        if (obs_io.size() != exp_io.size() || pc !== 8'h2E) begin
            n_fail++;
            $display("FAIL alu_path: %0d outputs pc=%h required %0d/2E", obs_io.size(), pc, exp_io.size());
        end
        while (exp_io.size() > 0 && obs_io.size() > 0) begin
            logic [DW-1:0] e, o;
            e = exp_io.pop_front();
            o = obs_io.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL alu_value: out %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int c;
        start_reset();
        release_reset();
        repeat (7) @(negedge clock);
        idly = 1000;
        c = 0;
        while (!imem_req && c < 20) begin
            @(negedge clock);
            c++;
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (imem_req !== 1'b1 || pc === 8'h00) begin
            n_fail++;
            $display("FAIL stall_setup: imem_req=%b pc=%h required 1/nonzero", imem_req, pc);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: imem_req=%b pc=%h required 0/00", imem_req, pc);
        end
        idly = 0;
        obs_fetch.delete();
        exp_fetch.push_back(8'h00);
        release_reset();
        c = 0;
        while (obs_fetch.size() == 0 && c < 20) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (obs_fetch.size() == 0) begin
            n_fail++;
            $display("FAIL restart_fetch: no fetch after reset, required one at 00");
        end else begin
            logic [AW-1:0] e, o;
            e = exp_fetch.pop_front();
            o = obs_fetch.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL restart_fetch: fetched %h required %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_add_jneg();
        test_store_stall();
        test_call_ret();
        test_stack_fault();
        test_io();
        test_alu_branches();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
